// File: rtl/fat32_boot_parser_pkg.sv
// rtl/fat32_boot_parser_pkg.sv - shared state, error and on-disk layout definitions for the FAT32 boot parser
package fat32_boot_parser_pkg;

  typedef enum logic [2:0] {
    IDLE, REQ0, RECV0, REQ1, RECV1, CALC, DONE, ERR
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_MBR_SIG    = 3'd1,
    ERR_DBR_SIG    = 3'd2,
    ERR_BPS        = 3'd3,
    ERR_ZERO_FIELD = 3'd4
  } err_code_t;

  localparam logic [31:0] OFF_BPS        = 32'h0B;
  localparam logic [31:0] OFF_SPC        = 32'h0D;
  localparam logic [31:0] OFF_RSVD       = 32'h0E;
  localparam logic [31:0] OFF_NFATS      = 32'h10;
  localparam logic [31:0] OFF_FATSZ      = 32'h24;
  localparam logic [31:0] OFF_ROOT       = 32'h2C;
  localparam logic [31:0] OFF_PART_TABLE = 32'h1BE;
  localparam logic [31:0] OFF_SIG0       = 32'h1FE;
  localparam logic [31:0] OFF_SIG1       = 32'h1FF;

  localparam int PART_ENTRY_BYTES = 16;
  localparam int PART_TYPE_OFS    = 4;
  localparam int PART_LBA_OFS     = 8;

  localparam logic [7:0] SIG0_VAL       = 8'h55;
  localparam logic [7:0] SIG1_VAL       = 8'hAA;
  localparam logic [7:0] JMP_SHORT      = 8'hEB;
  localparam logic [7:0] JMP_NEAR       = 8'hE9;
  localparam logic [7:0] TYPE_FAT32_CHS = 8'h0B;
  localparam logic [7:0] TYPE_FAT32_LBA = 8'h0C;

  // Little-endian field assembly: drop byte d into cur if addr falls inside [base, base+nbytes).
  function automatic logic [31:0] put_le(input logic [31:0] cur, input logic [31:0] addr,
                                         input logic [31:0] base, input int nbytes,
                                         input logic [7:0] d);
    logic [31:0] r;
    r = cur;
    for (int k = 0; k < 4; k++) begin
      if (k < nbytes && addr == base + 32'(k)) r[8*k +: 8] = d;
    end
    return r;
  endfunction

  function automatic logic is_fat32_type(input logic [7:0] t);
    return (t == TYPE_FAT32_CHS) || (t == TYPE_FAT32_LBA);
  endfunction

  function automatic logic is_boot_jump(input logic [7:0] b);
    return (b == JMP_SHORT) || (b == JMP_NEAR);
  endfunction

endpackage

// File: rtl/fat32_boot_parser_if.sv
// rtl/fat32_boot_parser_if.sv - sector request / byte stream link between the parser and the card reader
interface fat32_boot_parser_if;
  logic        sectorReq;
  logic [31:0] sectorLBA;
  logic        sectorAck;
  logic        byteValid;
  logic [7:0]  byteData;

  modport master (output sectorReq, sectorLBA, input sectorAck, byteValid, byteData);
  modport slave  (input sectorReq, sectorLBA, output sectorAck, byteValid, byteData);
endinterface

// File: rtl/sector_byte_counter.sv
// rtl/sector_byte_counter.sv - byte address counter for one sector, terminal flag on the last byte
module sector_byte_counter #(
  parameter int SECTOR_BYTES = 512,
  parameter int CNT_W        = 10
) (
  input  logic             Clock,
  input  logic             sys_rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SECTOR_BYTES - 1);

  assign terminal = (count == LAST);

  always_ff @(posedge Clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= terminal ? '0 : count + CNT_W'(1);
    end
  end
endmodule

// File: rtl/fat32_boot_parser.sv
// rtl/fat32_boot_parser.sv - reads MBR/DBR sectors and derives FAT32 volume geometry
module fat32_boot_parser
  import fat32_boot_parser_pkg::*;
#(
  parameter int SECTOR_BYTES = 512,
  parameter int PART_INDEX   = 0,
  parameter int CNT_W        = 10
) (
  input  logic                       Clock,
  input  logic                       sys_rst_n,
  input  logic                       start,
  fat32_boot_parser_if.master        sec,
  output logic [31:0]                partitionStart,
  output logic [31:0]                fatStart,
  output logic [31:0]                dataStart,
  output logic [31:0]                rootCluster,
  output logic [7:0]                 sectorsPerCluster,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [2:0]                 errorCode
);
  localparam logic [31:0] PT_TYPE = OFF_PART_TABLE + 32'(PART_ENTRY_BYTES * PART_INDEX + PART_TYPE_OFS);
  localparam logic [31:0] PT_LBA  = OFF_PART_TABLE + 32'(PART_ENTRY_BYTES * PART_INDEX + PART_LBA_OFS);

  state_t      state, state_n;
  err_code_t   err_n, bpb_err, err_code_q;
  logic        load_part, req, in_recv, cap, last_byte, sig_ok, terminal;
  logic [31:0] lba, addr;
  logic [CNT_W-1:0] byte_addr;

  logic [7:0]  byte0_q, ptype_q, spc_q, nfats_q, sig0_q, sig1_q, sig1_now, calc_left;
  logic [31:0] mbr_lba_q, bps_q, rsvd_q, fatsz_q, root_q;
  logic [31:0] part_q, fat_q, data_q;
  logic        calc_phase, done_q, error_q;

  assign in_recv   = (state == RECV0) || (state == RECV1);
  assign cap       = in_recv && sec.byteValid;
  assign last_byte = cap && terminal;
  assign addr      = 32'(byte_addr);

  sector_byte_counter #(
    .SECTOR_BYTES (SECTOR_BYTES),
    .CNT_W        (CNT_W)
  ) u_counter (
    .Clock     (Clock),
    .sys_rst_n (sys_rst_n),
    .clear     (!in_recv),
    .enable    (cap),
    .count     (byte_addr),
    .terminal  (terminal)
  );

  // The trailing signature byte can be the very byte that ends the sector, so bypass its register.
  assign sig1_now = (cap && addr == OFF_SIG1) ? sec.byteData : sig1_q;
  assign sig_ok   = (sig0_q == SIG0_VAL) && (sig1_now == SIG1_VAL);

  always_comb begin
    bpb_err = ERR_NONE;
    if (bps_q != 32'(SECTOR_BYTES)) begin
      bpb_err = ERR_BPS;
    end else if (nfats_q == 8'd0 || spc_q == 8'd0 || fatsz_q == 32'd0) begin
      bpb_err = ERR_ZERO_FIELD;
    end
  end

  always_ff @(posedge Clock or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n   = state;
    req       = 1'b0;
    lba       = 32'd0;
    err_n     = ERR_NONE;
    load_part = 1'b0;
    unique case (state)
      IDLE: if (start) state_n = REQ0;
      REQ0: begin
        req = 1'b1;
        if (sec.sectorAck) state_n = RECV0;
      end
      RECV0: if (last_byte) begin
        if (!sig_ok) begin
          state_n = ERR;
          err_n   = ERR_MBR_SIG;
        end else if (is_fat32_type(ptype_q)) begin
          state_n   = REQ1;
          load_part = 1'b1;
        end else if (is_boot_jump(byte0_q)) begin
          err_n   = bpb_err;
          state_n = (bpb_err == ERR_NONE) ? CALC : ERR;
        end else begin
          state_n = ERR;
          err_n   = ERR_MBR_SIG;
        end
      end
      REQ1: begin
        req = 1'b1;
        lba = part_q;
        if (sec.sectorAck) state_n = RECV1;
      end
      RECV1: if (last_byte) begin
        if (!sig_ok) begin
          state_n = ERR;
          err_n   = ERR_DBR_SIG;
        end else begin
          err_n   = bpb_err;
          state_n = (bpb_err == ERR_NONE) ? CALC : ERR;
        end
      end
      CALC: if (calc_phase && calc_left == 8'd1) state_n = DONE;
      DONE: state_n = IDLE;
      ERR:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      byte0_q    <= '0;
      ptype_q    <= '0;
      mbr_lba_q  <= '0;
      bps_q      <= '0;
      spc_q      <= '0;
      rsvd_q     <= '0;
      nfats_q    <= '0;
      fatsz_q    <= '0;
      root_q     <= '0;
      sig0_q     <= '0;
      sig1_q     <= '0;
      part_q     <= '0;
      fat_q      <= '0;
      data_q     <= '0;
      calc_left  <= '0;
      calc_phase <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
    end else if (state == IDLE && start) begin
      byte0_q    <= '0;
      ptype_q    <= '0;
      mbr_lba_q  <= '0;
      bps_q      <= '0;
      spc_q      <= '0;
      rsvd_q     <= '0;
      nfats_q    <= '0;
      fatsz_q    <= '0;
      root_q     <= '0;
      sig0_q     <= '0;
      sig1_q     <= '0;
      part_q     <= '0;
      fat_q      <= '0;
      data_q     <= '0;
      calc_left  <= '0;
      calc_phase <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      if (cap) begin
        // BPB fields are taken from sector 0 too, in case it turns out to be a superfloppy DBR.
        if (state == RECV0) begin
          if (addr == 32'd0) byte0_q <= sec.byteData;
          if (addr == PT_TYPE) ptype_q <= sec.byteData;
          mbr_lba_q <= put_le(mbr_lba_q, addr, PT_LBA, 4, sec.byteData);
        end
        bps_q   <= put_le(bps_q, addr, OFF_BPS, 2, sec.byteData);
        rsvd_q  <= put_le(rsvd_q, addr, OFF_RSVD, 2, sec.byteData);
        fatsz_q <= put_le(fatsz_q, addr, OFF_FATSZ, 4, sec.byteData);
        root_q  <= put_le(root_q, addr, OFF_ROOT, 4, sec.byteData);
        if (addr == OFF_SPC)   spc_q   <= sec.byteData;
        if (addr == OFF_NFATS) nfats_q <= sec.byteData;
        if (addr == OFF_SIG0)  sig0_q  <= sec.byteData;
        if (addr == OFF_SIG1)  sig1_q  <= sec.byteData;
      end
      if (load_part) part_q <= mbr_lba_q;
      if (state_n == CALC && state != CALC) begin
        calc_phase <= 1'b0;
        calc_left  <= nfats_q;
      end else if (state == CALC) begin
        if (!calc_phase) begin
          fat_q      <= part_q + rsvd_q;
          data_q     <= part_q + rsvd_q;
          calc_phase <= 1'b1;
        end else begin
          data_q    <= data_q + fatsz_q;
          calc_left <= calc_left - 8'd1;
        end
      end
      if (state_n == ERR && state != ERR) err_code_q <= err_n;
      if (state == DONE) done_q  <= 1'b1;
      if (state == ERR)  error_q <= 1'b1;
    end
  end

  assign sec.sectorReq     = req;
  assign sec.sectorLBA     = lba;
  assign partitionStart    = part_q;
  assign fatStart          = fat_q;
  assign dataStart         = data_q;
  assign rootCluster       = root_q;
  assign sectorsPerCluster = spc_q;
  assign busy              = (state != IDLE);
  assign done              = done_q;
  assign error             = error_q;
  assign errorCode         = err_code_q;
endmodule

// File: tb/tb_fat32_boot_parser.sv
// tb/tb_fat32_boot_parser.sv - directed bench for fat32_boot_parser with a sector-image reference model
module tb_fat32_boot_parser;

  logic        Clock     = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start     = 1'b0;
  logic [31:0] partitionStart, fatStart, dataStart, rootCluster;
  logic [7:0]  sectorsPerCluster;
  logic        busy, done, error;
  logic [2:0]  errorCode;

  fat32_boot_parser_if sec();

  fat32_boot_parser dut (
    .Clock             (Clock),
    .sys_rst_n         (sys_rst_n),
    .start             (start),
    .sec               (sec),
    .partitionStart    (partitionStart),
    .fatStart          (fatStart),
    .dataStart         (dataStart),
    .rootCluster       (rootCluster),
    .sectorsPerCluster (sectorsPerCluster),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .errorCode         (errorCode)
  );

  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  img [2][512];
  logic [2:0]  exp_err;
  logic [31:0] exp_part, exp_fat, exp_data, exp_root;
  logic [7:0]  exp_spc;
  int          exp_nreq = 0;
  int          req_idx  = 0;
  logic        prev_fin = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [31:0] rd_le(input int k, input int a, input int n);
    logic [31:0] v;
    v = 32'd0;
    for (int i = n - 1; i >= 0; i--) v = (v << 8) | {24'h0, img[k][a+i]};
    return v;
  endfunction

  // Reference: decide the volume layout directly from the two sector images.
  task automatic model();
    int k;
    logic [31:0] bps, rsvd, fsz;
    logic [7:0]  ptype, nf;
    exp_part = 0; exp_fat = 0; exp_data = 0; exp_root = 0; exp_spc = 0; exp_err = 0;
    k = 0;
    ptype = img[0][16'h1C2];
    if (!(img[0][510] == 8'h55 && img[0][511] == 8'hAA)) begin
      exp_err = 3'd1; exp_nreq = 1; return;
    end
    if (ptype == 8'h0B || ptype == 8'h0C) begin
      k = 1; exp_nreq = 2; exp_part = rd_le(0, 'h1C6, 4);
      if (!(img[1][510] == 8'h55 && img[1][511] == 8'hAA)) begin
        exp_err = 3'd2; return;
      end
    end else if (img[0][0] == 8'hEB || img[0][0] == 8'hE9) begin
      k = 0; exp_nreq = 1;
    end else begin
      exp_err = 3'd1; exp_nreq = 1; return;
    end
    bps      = rd_le(k, 'h0B, 2);
    rsvd     = rd_le(k, 'h0E, 2);
    fsz      = rd_le(k, 'h24, 4);
    nf       = img[k]['h10];
    exp_spc  = img[k]['h0D];
    exp_root = rd_le(k, 'h2C, 4);
    if (bps != 32'd512) exp_err = 3'd3;
    else if (nf == 0 || exp_spc == 0 || fsz == 0) exp_err = 3'd4;
    else begin
      exp_fat  = exp_part + rsvd;
      exp_data = exp_fat + 32'(nf) * fsz;
    end
  endtask

  task automatic fill();
    for (int k = 0; k < 2; k++)
      for (int b = 0; b < 512; b++) img[k][b] = 8'((b * 7 + k * 13) & 255);
  endtask

  task automatic set_sig(input int k, input logic [7:0] s0, input logic [7:0] s1);
    img[k][510] = s0;
    img[k][511] = s1;
  endtask

  task automatic set_mbr(input logic [7:0] b0, input logic [7:0] ptype, input logic [31:0] lba);
    img[0][0]      = b0;
    img[0]['h1C2]  = ptype;
    for (int i = 0; i < 4; i++) img[0]['h1C6+i] = lba[8*i +: 8];
  endtask

  task automatic set_bpb(input int k, input logic [15:0] bps, input logic [7:0] spc,
                         input logic [15:0] rsvd, input logic [7:0] nf,
                         input logic [31:0] fsz, input logic [31:0] root);
    img[k]['h0B] = bps[7:0];  img[k]['h0C] = bps[15:8];
    img[k]['h0D] = spc;
    img[k]['h0E] = rsvd[7:0]; img[k]['h0F] = rsvd[15:8];
    img[k]['h10] = nf;
    for (int i = 0; i < 4; i++) begin
      img[k]['h24+i] = fsz[8*i +: 8];
      img[k]['h2C+i] = root[8*i +: 8];
    end
  endtask

  task automatic std_fat();
    fill();
    set_mbr(8'h33, 8'h0C, 32'h0000_2000);
    set_sig(0, 8'h55, 8'hAA);
    set_bpb(1, 16'd512, 8'd8, 16'd32, 8'd2, 32'h3C1, 32'd2);
    set_sig(1, 8'h55, 8'hAA);
  endtask

  task automatic idle_gap(input int max_gap, input bit spam, inout int budget);
    int n;
    n = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    for (int i = 0; i < n; i++) begin
      if (spam && $urandom_range(0, 3) == 0) start = 1'b1;
      tick();
      start = 1'b0;
      budget--;
    end
  endtask

  task automatic run_parse(input int max_gap, input bit spam, input int abort_at);
    int budget;
    int k;
    bit fin, aborted;
    budget = 30000; fin = 0; aborted = 0;
    model();
    req_idx = 0;
    start = 1'b1; tick(); start = 1'b0;
    while (!fin && budget > 0) begin
      if (sec.sectorReq) begin
        k = (req_idx < 2) ? req_idx : 1;
        idle_gap(max_gap, spam, budget);
        sec.sectorAck = 1'b1; tick(); sec.sectorAck = 1'b0; budget--;
        req_idx++;
        for (int b = 0; b < 512 && !fin; b++) begin
          if (k == 1 && b == abort_at) begin
            sys_rst_n = 1'b0; fin = 1; aborted = 1;
          end else begin
            idle_gap(max_gap, spam, budget);
            sec.byteValid = 1'b1; sec.byteData = img[k][b]; tick(); budget--;
            sec.byteValid = 1'b0;
          end
        end
      end else if (done || error) begin
        fin = 1;
      end else begin
        tick(); budget--;
      end
    end
    if (!fin) begin
      checks++; failures++;
      $display("FAIL parse_timeout actual=no_done_or_error required=done_or_error");
    end
    tick(); tick();
    if (fin && !aborted) check("request_count", 32'(req_idx), 32'(exp_nreq));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_partitionStart"}, partitionStart, 32'd0);
    check({tag, "_fatStart"}, fatStart, 32'd0);
    check({tag, "_dataStart"}, dataStart, 32'd0);
    check({tag, "_rootCluster"}, rootCluster, 32'd0);
    check({tag, "_spc"}, 32'(sectorsPerCluster), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_errorCode"}, 32'(errorCode), 32'd0);
    check({tag, "_sectorReq"}, 32'(sec.sectorReq), 32'd0);
  endtask

  // Compare process: request addressing every cycle, full result set when a parse finishes.
  always @(negedge Clock) begin
    if (sys_rst_n) begin
      if (sec.sectorReq) begin
        check("request_within_expected", 32'(req_idx < exp_nreq), 32'd1);
        if (req_idx < exp_nreq)
          check("sectorLBA", sec.sectorLBA, (req_idx == 0) ? 32'd0 : exp_part);
      end
      if ((done || error) && !prev_fin) begin
        check("error_flag", 32'(error), 32'(exp_err != 0));
        check("done_flag", 32'(done), 32'(exp_err == 0));
        check("errorCode", 32'(errorCode), 32'(exp_err));
        check("busy_after_finish", 32'(busy), 32'd0);
        if (exp_err == 0) begin
          check("partitionStart", partitionStart, exp_part);
          check("fatStart", fatStart, exp_fat);
          check("dataStart", dataStart, exp_data);
          check("rootCluster", rootCluster, exp_root);
          check("sectorsPerCluster", 32'(sectorsPerCluster), 32'(exp_spc));
        end else begin
          check("dataStart_on_error", dataStart, 32'd0);
        end
      end
    end
    prev_fin = done || error;
  end

  initial begin
    sec.sectorAck = 1'b0;
    sec.byteValid = 1'b0;
    sec.byteData  = 8'h00;
    #2;
    check_zero("reset");
    repeat (3) @(posedge Clock);
    #1 sys_rst_n = 1'b1;
    repeat (5) begin
      tick();
      check("no_request_before_start", 32'(sec.sectorReq), 32'd0);
    end

    std_fat();
    run_parse(0, 0, -1);
    check("lit_fatStart", fatStart, 32'h2020);
    check("lit_dataStart", dataStart, 32'h27A2);
    check("lit_rootCluster", rootCluster, 32'd2);
    check("lit_model_data", exp_data, 32'h27A2);
    check("lit_done", 32'(done), 32'd1);

    std_fat();
    run_parse(5, 1, -1);
    check("gap_fatStart", fatStart, 32'h2020);
    check("gap_dataStart", dataStart, 32'h27A2);

    fill();
    set_mbr(8'hEB, 8'h00, 32'h0000_1234);
    set_sig(0, 8'h55, 8'hAA);
    set_bpb(0, 16'd512, 8'd4, 16'h20, 8'd2, 32'h100, 32'd2);
    run_parse(0, 0, -1);
    check("floppy_partitionStart", partitionStart, 32'd0);
    check("floppy_dataStart", dataStart, 32'h220);
    check("floppy_one_request", 32'(req_idx), 32'd1);

    std_fat();
    img[1][511] = 8'hAB;
    run_parse(0, 0, -1);
    check("dbr_sig_code", 32'(errorCode), 32'd2);
    check("dbr_sig_data", dataStart, 32'd0);

    std_fat();
    set_bpb(1, 16'd4096, 8'd8, 16'd32, 8'd2, 32'h3C1, 32'd2);
    run_parse(0, 0, -1);
    check("bps_code", 32'(errorCode), 32'd3);

    std_fat();
    set_bpb(1, 16'd512, 8'd8, 16'd32, 8'd0, 32'h3C1, 32'd2);
    run_parse(0, 0, -1);
    check("nfats_zero_code", 32'(errorCode), 32'd4);

    fill();
    set_mbr(8'hE9, 8'h00, 32'd0);
    set_sig(0, 8'h55, 8'hAA);
    set_bpb(0, 16'd512, 8'd1, 16'd32, 8'd2, 32'd0, 32'd2);
    run_parse(1, 1, -1);
    check("fatsz_zero_code", 32'(errorCode), 32'd4);

    std_fat();
    img[0][510] = 8'h54;
    run_parse(0, 0, -1);
    check("mbr_sig_code", 32'(errorCode), 32'd1);

    std_fat();
    set_mbr(8'h00, 8'h07, 32'h2000);
    run_parse(0, 0, -1);
    check("unknown_type_code", 32'(errorCode), 32'd1);

    fill();
    set_mbr(8'h33, 8'h0B, 32'hFFFF_FF00);
    set_sig(0, 8'h55, 8'hAA);
    set_bpb(1, 16'd512, 8'd1, 16'h200, 8'd3, 32'h6000_0000, 32'd5);
    set_sig(1, 8'h55, 8'hAA);
    run_parse(3, 0, -1);
    check("wrap_fatStart", fatStart, 32'h0000_0100);
    check("wrap_dataStart", dataStart, 32'h2000_0100);

    std_fat();
    run_parse(0, 0, 200);
    #1;
    check_zero("midsector_reset");
    repeat (2) @(posedge Clock);
    #1 sys_rst_n = 1'b1;
    repeat (10) begin
      tick();
      check("no_request_after_reset", 32'(sec.sectorReq), 32'd0);
    end
    std_fat();
    run_parse(2, 1, -1);
    check("post_reset_fatStart", fatStart, 32'h2020);
    check("post_reset_dataStart", dataStart, 32'h27A2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "simulation time limit");
  end

endmodule
